// File: rtl/wb_reg_slice.sv
// Registered Wishbone classic stage ahead of the slave address decoder.
// Optional response timeout: define WB_REG_SLICE_TIMEOUT_EN.
module wb_reg_slice #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                    wbm_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic                    wbm_stb_i,
  output logic                    wbm_ack_o,
  output logic                    wbm_err_o,
  output logic                    wbm_rty_o,
  input  logic                    wbm_cyc_i,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  output logic                    wbs_cyc_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic                    resp_in;
  logic                    expire;
  logic [ADDR_WIDTH-1:0]   adr_d;
  logic [DATA_WIDTH-1:0]   dat_d;
  logic [SELECT_WIDTH-1:0] sel_d;
  logic                    we_d;
  logic                    stb_d;
  logic                    cyc_d;
  logic [DATA_WIDTH-1:0]   mdat_d;
  logic                    ack_d;
  logic                    err_d;
  logic                    rty_d;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("wb_reg_slice: TIMEOUT must be at least 2");
  end

  assign resp_in = wbs_ack_i | wbs_err_i | wbs_rty_i;

`ifdef WB_REG_SLICE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Held at zero outside REQ, so the first REQ cycle always sees 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state != REQ) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = (state == REQ) && (cnt == CW'(TIMEOUT - 1));
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        if (!wbm_cyc_i) begin
          state_nx = IDLE;
        end else if (resp_in || expire) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    adr_d  = wbs_adr_o;
    dat_d  = wbs_dat_o;
    sel_d  = wbs_sel_o;
    we_d   = 1'b0;
    stb_d  = 1'b0;
    cyc_d  = wbs_cyc_o;
    mdat_d = wbm_dat_o;
    ack_d  = 1'b0;
    err_d  = 1'b0;
    rty_d  = 1'b0;
    unique case (state)
      IDLE: begin
        cyc_d = wbm_cyc_i;
        if (wbm_cyc_i && wbm_stb_i) begin
          adr_d = wbm_adr_i;
          dat_d = wbm_dat_i;
          sel_d = wbm_sel_i;
          we_d  = wbm_we_i;
          stb_d = 1'b1;
        end
      end
      REQ: begin
        // Abort outranks a same-cycle response, which is dropped.
        if (!wbm_cyc_i) begin
          cyc_d = 1'b0;
        end else if (resp_in) begin
          cyc_d  = 1'b1;
          mdat_d = wbs_dat_i;
          unique case (1'b1)
            wbs_err_i: err_d = 1'b1;
            wbs_rty_i: rty_d = 1'b1;
            default:   ack_d = 1'b1;
          endcase
        end else if (expire) begin
          cyc_d  = 1'b0;
          mdat_d = '0;
          err_d  = 1'b1;
        end else begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
          we_d  = wbs_we_o;
        end
      end
      RESP: begin
        // A timed-out cycle stays released until IDLE re-follows the master.
        cyc_d = wbs_cyc_o & wbm_cyc_i;
      end
      default: begin
        cyc_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      wbs_sel_o <= '0;
      wbs_we_o  <= 1'b0;
      wbs_stb_o <= 1'b0;
      wbs_cyc_o <= 1'b0;
      wbm_dat_o <= '0;
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
      wbm_rty_o <= 1'b0;
    end else begin
      wbs_adr_o <= adr_d;
      wbs_dat_o <= dat_d;
      wbs_sel_o <= sel_d;
      wbs_we_o  <= we_d;
      wbs_stb_o <= stb_d;
      wbs_cyc_o <= cyc_d;
      wbm_dat_o <= mdat_d;
      wbm_ack_o <= ack_d;
      wbm_err_o <= err_d;
      wbm_rty_o <= rty_d;
    end
  end

endmodule
